// File: rtl/wcb_pkg.sv
// Shared types for the write-combining buffer: FSM states, line entry layout
// and the byte-merge helper.
package wcb_pkg;
  localparam int unsigned MAX_WORDS = 8;
  localparam int unsigned WORD_W    = 3;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } wcb_state_e;

  // Words beyond LINE_WORDS are never written and keep a zero strobe.
  typedef struct packed {
    logic                           valid;
    logic [31:0]                    base;
    logic [MAX_WORDS-1:0][31:0]     data;
    logic [MAX_WORDS-1:0][3:0]      strb;
  } wcb_entry_t;

  function automatic logic [31:0] merge_word(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction
endpackage

// File: rtl/wcb_age_fifo.sv
// Allocation-order queue of entry indices; the head is the oldest valid line.
module wcb_age_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [$clog2(DEPTH)-1:0]   push_idx,
  input  logic                       pop,
  output logic [$clog2(DEPTH)-1:0]   oldest,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [IDX_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0] rd_ptr;
  logic [IDX_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_idx;
        wr_ptr      <= wr_ptr + IDX_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + IDX_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign oldest = mem[rd_ptr];
  assign count  = cnt;
endmodule

// File: rtl/write_combine_buf.sv
// Write-combining store buffer: merges byte stores into line entries and
// drains whole lines oldest-first as sparse word bursts.
module write_combine_buf
  import wcb_pkg::*;
#(
  parameter int unsigned ENTRIES    = 8,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [31:0]                 in_addr,
  input  logic [31:0]                 in_wdata,
  input  logic [3:0]                  in_wstrb,
  output logic                        in_ready,
  input  logic                        flush,
  output logic                        flush_done,
  output logic                        out_valid,
  output logic [31:0]                 out_addr,
  output logic [31:0]                 out_wdata,
  output logic [3:0]                  out_wstrb,
  output logic                        out_last,
  input  logic                        out_ready,
  input  logic [31:0]                 chk_addr,
  output logic                        chk_hit,
  output logic                        busy,
  output logic [$clog2(ENTRIES):0]    count
);
  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned OFFS   = $clog2(LINE_WORDS * 4);
  localparam int unsigned IDLE_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WORD_W-1:0] WMASK = WORD_W'(LINE_WORDS - 1);

  wcb_entry_t        entries [ENTRIES];
  wcb_state_e        state;
  logic [WORD_W:0]   next_word;
  logic              flush_pend;
  logic [IDLE_W-1:0] idle_cnt;

  logic [31:0]       in_base, chk_base;
  logic [WORD_W-1:0] in_word, chk_word;
  logic              hit, free_found;
  logic [IDX_W-1:0]  hit_idx, free_idx, upd_idx, oldest;
  wcb_entry_t        upd_entry;
  logic              found, more;
  logic [WORD_W-1:0] sel_w;
  logic              accept, alloc, timeout_hit, start_drain;
  logic              last_hs, empty_line, load, free_line;

  assign in_base  = 32'(in_addr >> OFFS);
  assign in_word  = WORD_W'(in_addr >> 2) & WMASK;
  assign chk_base = 32'(chk_addr >> OFFS);
  assign chk_word = WORD_W'(chk_addr >> 2) & WMASK;

  // Tag match for the store, lowest free slot, and the load-hazard probe.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    chk_hit    = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (entries[i].valid && entries[i].base == in_base) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!entries[i].valid && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (entries[i].valid && entries[i].base == chk_base &&
          entries[i].strb[chk_word] != 4'h0)
        chk_hit = 1'b1;
    end
  end

  // Next nonempty word of the draining line at or after next_word.
  always_comb begin
    found = 1'b0;
    more  = 1'b0;
    sel_w = '0;
    for (int w = 0; w < MAX_WORDS; w++) begin
      if (entries[oldest].strb[w] != 4'h0 && (WORD_W+1)'(w) >= next_word) begin
        if (found) more = 1'b1;
        else begin
          found = 1'b1;
          sel_w = WORD_W'(w);
        end
      end
    end
  end

  always_comb begin
    upd_idx        = hit ? hit_idx : free_idx;
    upd_entry      = hit ? entries[hit_idx] : '0;
    upd_entry.valid = 1'b1;
    upd_entry.base  = in_base;
    upd_entry.data[in_word] = merge_word(upd_entry.data[in_word], in_wdata, in_wstrb);
    upd_entry.strb[in_word] = upd_entry.strb[in_word] | in_wstrb;
  end

  assign in_ready    = !flush_pend && (hit || free_found) &&
                       !(hit && state == DRAIN && hit_idx == oldest);
  assign accept      = in_valid && in_ready;
  assign alloc       = accept && !hit;
  assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == IDLE_W'(TIMEOUT));
  assign start_drain = (state == ACCUM) && (count != '0) &&
                       ((in_valid && !hit && !free_found) || timeout_hit || flush_pend);
  assign last_hs     = (state == DRAIN) && out_valid && out_ready && out_last;
  assign empty_line  = (state == DRAIN) && !out_valid && !found;
  assign free_line   = last_hs || empty_line;
  assign load        = (state == DRAIN) && found &&
                       (!out_valid || (out_ready && !out_last));

  assign flush_done  = flush_pend && (count == '0) && (state == ACCUM);
  assign busy        = (count != '0) || (state != ACCUM) || flush_pend;

  wcb_age_fifo #(.DEPTH(ENTRIES)) u_age (
    .clk      (clk),
    .rst      (rst),
    .push     (alloc),
    .push_idx (free_idx),
    .pop      (free_line),
    .oldest   (oldest),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCUM;
      next_word  <= '0;
      flush_pend <= 1'b0;
      idle_cnt   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_addr   <= '0;
      out_wdata  <= '0;
      out_wstrb  <= '0;
      for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
    end else begin
      if (accept) entries[upd_idx] <= upd_entry;
      if (free_line) entries[oldest].valid <= 1'b0;

      flush_pend <= (flush_pend && !flush_done) || flush;

      // A timeout fires a single drain, so the counter restarts with it.
      if (accept || (start_drain && timeout_hit)) idle_cnt <= '0;
      else if (idle_cnt != IDLE_W'(TIMEOUT))      idle_cnt <= idle_cnt + IDLE_W'(1);

      case (state)
        ACCUM: begin
          if (start_drain) state <= DRAIN;
        end
        DRAIN: begin
          if (free_line) begin
            state     <= (flush_pend && count > CNT_W'(1)) ? DRAIN : ACCUM;
            next_word <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (load) begin
            out_valid <= 1'b1;
            out_addr  <= (entries[oldest].base << OFFS) | (32'(sel_w) << 2);
            out_wdata <= entries[oldest].data[sel_w];
            out_wstrb <= entries[oldest].strb[sel_w];
            out_last  <= !more;
            next_word <= (WORD_W+1)'(sel_w) + (WORD_W+1)'(1);
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: doc/write_combine_buf.md
WRITE_COMBINE_BUF -- requirements
Module: write_combine_buf

Interface
REQ-001 SHALL have parameter ENTRIES, default 8: number of line entries; power of two, 2..16.
REQ-002 SHALL have parameter LINE_WORDS, default 4: 32-bit words per line; one of 2, 4 or 8.
REQ-003 SHALL have parameter TIMEOUT, default 64: idle cycles before an automatic drain; 0 disables it.
REQ-004 SHALL have ports clk in 1 (sole clock) and rst in 1; reset is synchronous and active-high.
REQ-005 SHALL have ports in_valid in 1, in_addr in 32, in_wdata in 32, in_wstrb in 4, in_ready out 1: incoming store stream.
REQ-006 SHALL have ports flush in 1 (drain-all request) and flush_done out 1 (one-cycle pulse when the buffer is empty).
REQ-007 SHALL have ports out_valid out 1, out_addr out 32, out_wdata out 32, out_wstrb out 4, out_last out 1, out_ready in 1: word burst per drained line.
REQ-008 SHALL have ports chk_addr in 32 and chk_hit out 1: load-hazard probe.
REQ-009 SHALL have ports busy out 1 and count out $clog2(ENTRIES)+1: number of valid entries.

Function
REQ-010 Line base SHALL be in_addr[31:$clog2(LINE_WORDS*4)]; the word index SHALL be the next bits up from bit 2; in_addr[1:0] SHALL be ignored.
REQ-011 Store accepted on in_valid && in_ready; a hit SHALL merge byte-wise: only bytes with strobe set SHALL overwrite data and set their strobe bit; other bytes SHALL be kept.
REQ-012 On a miss with a free entry, the lowest-index free entry SHALL be allocated with data and strobes zero before the merge, and it SHALL become the youngest in age order.
REQ-013 in_ready SHALL be 0 when any of these holds: flush pending; a miss with no free entry; a hit on the entry currently being drained.
REQ-014 FSM states SHALL be ACCUM and DRAIN; ACCUM->DRAIN SHALL occur when the buffer is full and a miss stalls, on a timeout, or when flush is pending and count>0.
REQ-015 Drain victim SHALL always be the oldest valid entry; flush SHALL drain entries oldest-first until count==0.
REQ-016 DRAIN SHALL emit only words with a nonzero strobe, in ascending word order, with out_addr = {base, word, 2'b00}.
REQ-017 out_last SHALL be 1 on the last nonempty word of the line; words with a zero strobe SHALL cost no cycles.
REQ-018 out_* SHALL stay stable while out_valid && !out_ready.
REQ-019 The handshake that sends the out_last beat SHALL invalidate the entry in that same cycle; the next cycle SHALL be ACCUM, or DRAIN of the next oldest entry if flush is still pending.
REQ-020 Stores hitting other, non-draining entries SHALL be accepted during DRAIN.
REQ-021 A store accepted in the cycle an entry frees SHALL see that entry as not yet free.
REQ-022 The idle counter SHALL reset on every accepted store and saturate at TIMEOUT; at TIMEOUT with count>0 in ACCUM it SHALL trigger one oldest-entry drain.
REQ-023 flush SHALL set a sticky pending bit; that bit SHALL clear, and flush_done SHALL pulse, in the first cycle count==0 and the FSM is in ACCUM.
REQ-024 flush with an already empty buffer SHALL pulse flush_done in the next cycle.
REQ-025 chk_hit SHALL be combinational: 1 iff a valid entry base equals the chk_addr line base and the addressed word has a nonzero strobe.
REQ-026 busy SHALL equal (count!=0) || (state!=ACCUM) || flush pending.

Reset
REQ-027 On rst the block SHALL clear all entries, the age order, the idle counter and the pending bit, and enter ACCUM.
REQ-028 Outputs after reset SHALL be: in_ready=1, out_valid=0, out_last=0, out_addr/out_wdata/out_wstrb=0, flush_done=0, chk_hit=0, busy=0, count=0.
REQ-029 rst during DRAIN SHALL abandon the burst; no further beats SHALL be emitted.

Structure
REQ-030 Package wcb_pkg SHALL hold the state enum and the entry struct (valid, base, data, strb) parameterised via localparams.
REQ-031 Sub-module wcb_age_fifo SHALL hold the allocation-order queue of entry indices, with push, pop and oldest ports.

Verification
REQ-032 Stores 0x100/0x11223344/0xF then 0x100/0xAABBCCDD/0x2 then flush -> one beat: addr 0x100, data 0x1122CC44, strb 0xF, last=1; flush_done pulses.
REQ-033 With LINE_WORDS=4, stores to 0x200 and 0x20C then flush -> two beats, 0x200 then 0x20C, last only on 0x20C; no beat for 0x204 or 0x208.
REQ-034 Fill all 8 lines, then store to a 9th line -> in_ready=0 until the oldest line drains; the 9th store is then accepted; count returns to 8.
REQ-035 TIMEOUT=4, a single store then idle -> drain starts 4 cycles after the store; out_ready held low 3 cycles -> beat stable throughout.
REQ-036 Store to 0x300, probe chk_addr=0x300 -> chk_hit=1; probe 0x304 -> 0; after the drain completes, probe 0x300 -> 0.
REQ-037 Assert rst mid-burst -> out_valid=0 next cycle, count=0, in_ready=1.
